two_bit_decoder_seq: RTL and testbench

TWO_BIT_DECODER_SEQ -- requirements
Module: two_bit_decoder_seq

---
 rtl/decoder_pkg.sv | 18 +
 rtl/scan_counter.sv | 31 +++
 rtl/two_bit_decoder_seq.sv | 173 +++++++++++++++++
 tb/tb_two_bit_decoder_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the two-bit sequential decoder: FSM state encoding,
// scan bounds and the code-to-one-hot helper.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN_EMIT = 2'd1,
        ST_SCAN_GAP  = 2'd2,
        ST_SCAN_END  = 2'd3
    } state_t;

    localparam logic [1:0] SCAN_LAST_IDX = 2'd3;

    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Small loadable up-counter with a terminal-count compare, used for both the
// scan index and the idle-gap timer.
module scan_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/two_bit_decoder_seq.sv
// Registered 2-to-4 decoder with valid/ready handshakes, a transfer counter and
// a self-test scan mode that walks codes 0..3 with configurable idle gaps.
module two_bit_decoder_seq
    import decoder_pkg::*;
#(
    parameter int SCAN_GAP = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_code,
    output logic             in_ready,
    input  logic             scan_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_onehot,
    output logic [1:0]       out_code,
    output logic             scan_done,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Gap counter runs 0..SCAN_GAP-1 while in the gap state.
    localparam logic [3:0] GAP_LAST = (SCAN_GAP > 0) ? 4'(SCAN_GAP - 1) : 4'd0;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_out_valid;
    logic [3:0]         r_out_onehot;
    logic [1:0]         r_out_code;
    logic               r_scan_done;
    logic [CNT_W-1:0]   r_xfer_cnt;

    logic               w_out_fire;
    logic               w_out_free;
    logic               w_in_fire;
    logic               w_emit_load;
    logic [1:0]         w_emit_code;
    logic               w_idx_load;
    logic               w_idx_en;
    logic [1:0]         w_idx;
    logic               w_idx_tc;
    logic               w_gap_load;
    logic               w_gap_en;
    logic [3:0]         w_gap_count_unused;
    logic               w_gap_tc;

    assign w_out_fire = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;
    // A scan request wins over a pending input, so the input is refused that cycle.
    assign in_ready   = !rst && (r_state == ST_IDLE) && w_out_free && !scan_en;
    assign w_in_fire  = in_valid && in_ready;

    scan_counter #(.W(2)) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_idx_load),
        .i_load_val (2'd0),
        .i_en       (w_idx_en),
        .i_term     (SCAN_LAST_IDX),
        .o_count    (w_idx),
        .o_tc       (w_idx_tc)
    );

    scan_counter #(.W(4)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (4'd0),
        .i_en       (w_gap_en),
        .i_term     (GAP_LAST),
        .o_count    (w_gap_count_unused),
        .o_tc       (w_gap_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_emit_load  = 1'b0;
        w_emit_code  = 2'd0;
        w_idx_load   = 1'b0;
        w_idx_en     = 1'b0;
        w_gap_load   = 1'b0;
        w_gap_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scan_en && w_out_free) begin
                    w_next_state = ST_SCAN_EMIT;
                    w_emit_load  = 1'b1;
                    w_idx_load   = 1'b1;
                end
            end
            ST_SCAN_EMIT: begin
                if (w_out_fire) begin
                    if (!scan_en) begin
                        w_next_state = ST_IDLE;
                    end else if (w_idx_tc) begin
                        w_next_state = ST_SCAN_END;
                    end else if (SCAN_GAP == 0) begin
                        w_next_state = ST_SCAN_EMIT;
                        w_idx_en     = 1'b1;
                        w_emit_load  = 1'b1;
                        w_emit_code  = w_idx + 2'd1;
                    end else begin
                        w_next_state = ST_SCAN_GAP;
                        w_idx_en     = 1'b1;
                        w_gap_load   = 1'b1;
                    end
                end
            end
            ST_SCAN_GAP: begin
                if (!scan_en) begin
                    w_next_state = ST_IDLE;
                end else if (w_gap_tc) begin
                    w_next_state = ST_SCAN_EMIT;
                    w_emit_load  = 1'b1;
                    w_emit_code  = w_idx;
                end else begin
                    w_gap_en = 1'b1;
                end
            end
            ST_SCAN_END: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Scan loads and input loads are mutually exclusive because in_ready is low under scan_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_onehot <= 4'b0000;
            r_out_code   <= 2'd0;
            r_scan_done  <= 1'b0;
            r_xfer_cnt   <= '0;
        end else begin
            if (w_emit_load) begin
                r_out_valid  <= 1'b1;
                r_out_onehot <= code_to_onehot(w_emit_code);
                r_out_code   <= w_emit_code;
            end else if (w_in_fire) begin
                r_out_valid  <= 1'b1;
                r_out_onehot <= code_to_onehot(in_code);
                r_out_code   <= in_code;
            end else if (w_out_fire) begin
                r_out_valid  <= 1'b0;
                r_out_onehot <= 4'b0000;
                r_out_code   <= 2'd0;
            end
            if (w_out_fire) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
            r_scan_done <= (w_next_state == ST_SCAN_END);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_onehot = r_out_onehot;
    assign out_code   = r_out_code;
    assign scan_done  = r_scan_done;
    assign xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_two_bit_decoder_seq.sv
// Directed self-checking bench for two_bit_decoder_seq (SCAN_GAP=2, CNT_W=8).
module tb_two_bit_decoder_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic       scan_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_onehot;
    logic [1:0] out_code;
    logic       scan_done;
    logic [7:0] xfer_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] onehot_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    two_bit_decoder_seq #(.SCAN_GAP(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .scan_en    (scan_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .scan_done  (scan_done),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        scan_en   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        scan_en   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_onehot, out_code, scan_done} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000000", {out_valid, out_onehot, out_code, scan_done});
        end
        checks++;
        if (xfer_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_xfer_cnt: got %0d expected 0", xfer_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd2;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_onehot, out_code} !== 7'b1_0100_10) begin
            errors++;
            $display("[TB] FAIL single_code2: got %b expected 1010010", {out_valid, out_onehot, out_code});
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd1 || out_valid !== 1'b0 || out_onehot !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_after: got cnt=%0d valid=%b onehot=%b expected cnt=1 valid=0 onehot=0000", xfer_cnt, out_valid, out_onehot);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== onehot_tbl[i] || out_code !== 2'(i)) begin
                errors++;
                $display("[TB] FAIL stream_out[%0d]: got valid=%b onehot=%b code=%0d expected 1 %b %0d", i, out_valid, out_onehot, out_code, onehot_tbl[i], i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (xfer_cnt !== 8'd4) begin
            errors++;
            $display("[TB] FAIL stream_xfer_cnt: got %0d expected 4", xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 2'd3;
        tick();
        in_code = 2'd0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== 4'b1000 || out_code !== 2'd3 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b onehot=%b code=%0d in_ready=%b expected 1 1000 3 0", i, out_valid, out_onehot, out_code, in_ready);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (xfer_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got cnt=%0d valid=%b expected cnt=1 valid=0", xfer_cnt, out_valid);
        end
    endtask

    task automatic test_scan();
        logic [5:0] expv;
        do_reset();
        out_ready = 1'b1;
        scan_en   = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL scan_priority_in_ready: got %b expected 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:       expv = 6'b1_0001_0;
                3:       expv = 6'b1_0010_0;
                6:       expv = 6'b1_0100_0;
                9:       expv = 6'b1_1000_0;
                10:      expv = 6'b0_0000_1;
                default: expv = 6'b0_0000_0;
            endcase
            checks++;
            if ({out_valid, out_onehot, scan_done} !== expv) begin
                errors++;
                $display("[TB] FAIL scan_cycle[%0d]: got %b expected %b", k, {out_valid, out_onehot, scan_done}, expv);
            end
            if (k == 10) scan_en = 1'b0;
            tick();
        end
        checks++;
        if (xfer_cnt !== 8'd4 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL scan_end: got cnt=%0d in_ready=%b expected cnt=4 in_ready=1", xfer_cnt, in_ready);
        end
    endtask

    task automatic test_scan_abort();
        do_reset();
        out_ready = 1'b1;
        scan_en   = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL abort_code1: got valid=%b onehot=%b expected 1 0010", out_valid, out_onehot);
        end
        tick();
        scan_en = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle: got in_ready=%b expected 1", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (out_valid !== 1'b0 || scan_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_quiet[%0d]: got valid=%b done=%b expected 0 0", k, out_valid, scan_done);
            end
            tick();
        end
        checks++;
        if (xfer_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL abort_xfer_cnt: got %0d expected 2", xfer_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd0;
        tick();
        in_code = 2'd1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_onehot !== 4'b0010 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got onehot=%b cnt=%0d expected 0010 1", out_onehot, xfer_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_in_ready: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || xfer_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got valid=%b onehot=%b cnt=%0d expected 0 0000 0", out_valid, out_onehot, xfer_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_code = 2'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (xfer_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL wrap_255: got %0d expected 255", xfer_cnt);
        end
        tick();
        checks++;
        if (xfer_cnt !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_zero: got cnt=%0d valid=%b expected 0 0", xfer_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_scan();
        test_scan_abort();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
